fetch_sequencer: RTL and testbench

Sequences the miniMIPS 4-byte instruction fetch over the 8-bit memory bus. It drives the byte address and read strobe, and waits on memory ready. It pulses one of the four 8-bit fetch-register load strobes per byte, then presents a valid instruction to decode with a valid/ack handshake. It owns the PC and accepts PC loads (branch/jump) from execute.

---
 rtl/fetch_sequencer_pkg.sv | 15 +
 rtl/fetch_sequencer_pc_counter.sv | 24 ++
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared miniMIPS fetch constants and state encoding
package fetch_sequencer_pkg;

    localparam int FS_ADDR_W = 8;
    localparam int FS_NBYTES = 4;
    localparam logic [FS_ADDR_W-1:0] FS_RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_LATCH = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// rtl/fetch_sequencer_pc_counter.sv - program counter with async clear, priority load and increment
module fetch_sequencer_pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              CLR_B,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - byte-serial instruction fetch FSM driving the 8-bit memory bus
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = FS_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FS_RESET_PC),
    parameter int                NBYTES   = FS_NBYTES
) (
    input  logic              CLK,
    input  logic              CLR_B,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_rdy,
    output logic [NBYTES-1:0] latch,
    output logic              instr_valid,
    input  logic              instr_ack,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              busy
);

    localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [NBYTES-1:0] STROBE0  = NBYTES'(1);

    fetch_state_t      state;
    logic [IDX_W-1:0]  byte_idx;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    // The counter gives pc_load priority, so a branch during LATCH wins over the step.
    assign pc_inc   = (state == ST_LATCH);
    assign mem_addr = pc;

    fetch_sequencer_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .CLK      (CLK),
        .CLR_B    (CLR_B),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            state       <= ST_IDLE;
            byte_idx    <= '0;
            mem_rd      <= 1'b0;
            latch       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
        end else if (pc_load) begin
            byte_idx    <= '0;
            latch       <= '0;
            instr_valid <= 1'b0;
            if (state != ST_IDLE || run) begin
                state  <= ST_READ;
                mem_rd <= 1'b1;
                busy   <= 1'b1;
            end else begin
                state  <= ST_IDLE;
                mem_rd <= 1'b0;
                busy   <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_READ;
                        byte_idx <= '0;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (mem_rdy) begin
                        state <= ST_LATCH;
                        latch <= STROBE0 << byte_idx;
                    end
                end
                ST_LATCH: begin
                    latch <= '0;
                    if (byte_idx == LAST_IDX) begin
                        state       <= ST_HOLD;
                        byte_idx    <= '0;
                        mem_rd      <= 1'b0;
                        instr_valid <= 1'b1;
                    end else begin
                        state    <= ST_READ;
                        byte_idx <= byte_idx + IDX_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        if (run) begin
                            state  <= ST_READ;
                            mem_rd <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_rd <= 1'b0;
                    latch  <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic       CLK = 1'b0;
    logic       CLR_B = 1'b0;
    logic       run = 1'b0;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_rdy;
    logic [3:0] latch;
    logic       instr_valid;
    logic       instr_ack = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_val = 8'h00;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];
    logic [7:0] dp  [0:3];
    int wait_cfg = 0;
    int wcnt = 0;

    fetch_sequencer dut (
        .CLK         (CLK),
        .CLR_B       (CLR_B),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdy     (mem_rdy),
        .latch       (latch),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // Memory inserts wait_cfg wait states at the start of every byte read.
    assign mem_rdy = (wcnt >= wait_cfg);

    always @(posedge CLK) begin
        if (!mem_rd || latch != 4'b0000) wcnt <= 0;
        else if (!mem_rdy) wcnt <= wcnt + 1;
        for (int i = 0; i < 4; i++) if (latch[i]) dp[i] <= mem[mem_addr];
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        CLR_B = 1'b0; run = 1'b0;
        repeat (2) step();
        checks++; if (latch !== 4'b0000 || mem_rd !== 1'b0) begin errors++; $display("FAIL reset_held: latch=%b mem_rd=%b want 0000/0", latch, mem_rd); end
        CLR_B = 1'b1;
        repeat (5) step();
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL idle_mem_rd: got %b want 0", mem_rd); end
        checks++; if (latch !== 4'b0000) begin errors++; $display("FAIL idle_latch: got %b want 0000", latch); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", instr_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL idle_addr: got %h want 00", mem_addr); end
    endtask

    task automatic test_single_fetch();
        logic [3:0] exp_l;
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        run = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            exp_l = (c % 2 == 0 && c <= 8) ? (4'b0001 << (c / 2 - 1)) : 4'b0000;
            checks++; if (latch !== exp_l) begin errors++; $display("FAIL single_latch c%0d: got %b want %b", c, latch, exp_l); end
            checks++; if (instr_valid !== (c == 9)) begin errors++; $display("FAIL single_valid c%0d: got %b want %b", c, instr_valid, (c == 9)); end
            checks++; if (mem_rd !== (c <= 8)) begin errors++; $display("FAIL single_rd c%0d: got %b want %b", c, mem_rd, (c <= 8)); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dp[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, dp[i], exp_b[i]); end
        end
        checks++; if (mem_addr !== 8'h04) begin errors++; $display("FAIL single_addr: got %h want 04", mem_addr); end
        instr_ack = 1'b1; run = 1'b0;
        step();
        instr_ack = 1'b0;
        checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL single_ack_idle: busy=%b valid=%b want 0/0", busy, instr_valid); end
    endtask

    task automatic test_wait_states();
        int pulses = 0, multi = 0, rd_drop = 0, valid_cyc = 0;
        logic [7:0] exp_b [4];
        exp_b = '{8'h55, 8'h66, 8'h77, 8'h88};
        wait_cfg = 3;
        run = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (c == 1) run = 1'b0;
            if (latch != 4'b0000) pulses++;
            if ((latch & (latch - 4'b0001)) != 4'b0000) multi++;
            if (valid_cyc == 0) begin
                if (instr_valid) valid_cyc = c;
                else if (!mem_rd) rd_drop++;
            end
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL wait_pulses: got %0d want 4", pulses); end
        checks++; if (multi !== 0) begin errors++; $display("FAIL wait_onehot: got %0d multi-hot want 0", multi); end
        checks++; if (rd_drop !== 0) begin errors++; $display("FAIL wait_rd_held: got %0d drops want 0", rd_drop); end
        checks++; if (valid_cyc !== 21) begin errors++; $display("FAIL wait_valid_cycle: got %0d want 21", valid_cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dp[i] !== exp_b[i]) begin errors++; $display("FAIL wait_byte%0d: got %h want %h", i, dp[i], exp_b[i]); end
        end
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        wait_cfg = 0;
        checks++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b mem_rd=%b want 0/0", busy, mem_rd); end
        checks++; if (mem_addr !== 8'h08) begin errors++; $display("FAIL wait_addr: got %h want 08", mem_addr); end
    endtask

    task automatic test_branch();
        logic [3:0] exp_l;
        logic [7:0] exp_b [4];
        exp_b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        run = 1'b1;
        repeat (4) step();
        checks++; if (latch !== 4'b0010 || mem_addr !== 8'h09) begin errors++; $display("FAIL branch_pre: latch=%b addr=%h want 0010/09", latch, mem_addr); end
        pc_load = 1'b1; pc_load_val = 8'h40;
        step();
        pc_load = 1'b0;
        checks++; if (mem_addr !== 8'h40) begin errors++; $display("FAIL branch_addr: got %h want 40", mem_addr); end
        checks++; if (mem_rd !== 1'b1 || latch !== 4'b0000 || instr_valid !== 1'b0) begin errors++; $display("FAIL branch_state: rd=%b latch=%b valid=%b want 1/0000/0", mem_rd, latch, instr_valid); end
        for (int c = 6; c <= 13; c++) begin
            step();
            exp_l = (c % 2 == 0 && c <= 12) ? (4'b0001 << ((c - 6) / 2)) : 4'b0000;
            checks++; if (latch !== exp_l) begin errors++; $display("FAIL branch_latch c%0d: got %b want %b", c, latch, exp_l); end
            checks++; if (instr_valid !== (c == 13)) begin errors++; $display("FAIL branch_valid c%0d: got %b want %b", c, instr_valid, (c == 13)); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dp[i] !== exp_b[i]) begin errors++; $display("FAIL branch_byte%0d: got %h want %h", i, dp[i], exp_b[i]); end
        end
        checks++; if (mem_addr !== 8'h44) begin errors++; $display("FAIL branch_end_addr: got %h want 44", mem_addr); end
        instr_ack = 1'b1; run = 1'b0;
        step();
        instr_ack = 1'b0;
    endtask

    task automatic test_priority_wrap();
        logic [7:0] exp_a;
        logic [7:0] exp_b [4];
        exp_b = '{8'hA1, 8'hB2, 8'h11, 8'h22};
        pc_load = 1'b1; pc_load_val = 8'hFE;
        step();
        pc_load = 1'b0;
        checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 8'hFE) begin errors++; $display("FAIL load_idle: busy=%b rd=%b addr=%h want 0/0/fe", busy, mem_rd, mem_addr); end
        run = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c % 2 == 0 && c <= 8) begin
                exp_a = 8'hFE + 8'(c / 2 - 1);
                checks++; if (mem_addr !== exp_a) begin errors++; $display("FAIL wrap_addr c%0d: got %h want %h", c, mem_addr, exp_a); end
            end
        end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dp[i] !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, dp[i], exp_b[i]); end
        end
        instr_ack = 1'b1; pc_load = 1'b1; pc_load_val = 8'h80;
        step();
        instr_ack = 1'b0; pc_load = 1'b0;
        checks++; if (mem_addr !== 8'h80) begin errors++; $display("FAIL prio_addr: got %h want 80", mem_addr); end
        checks++; if (mem_rd !== 1'b1 || instr_valid !== 1'b0 || latch !== 4'b0000) begin errors++; $display("FAIL prio_state: rd=%b valid=%b latch=%b want 1/0/0000", mem_rd, instr_valid, latch); end
        step();
        checks++; if (latch !== 4'b0001 || mem_addr !== 8'h80) begin errors++; $display("FAIL prio_latch: latch=%b addr=%h want 0001/80", latch, mem_addr); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        CLR_B = 1'b0;
        #1;
        checks++; if (latch !== 4'b0000) begin errors++; $display("FAIL rst_mid_latch: got %b want 0000", latch); end
        checks++; if (mem_rd !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl: rd=%b busy=%b valid=%b want 0/0/0", mem_rd, busy, instr_valid); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_pc: got %h want 00", mem_addr); end
        @(posedge CLK); #1;
        checks++; if (latch !== 4'b0000) begin errors++; $display("FAIL rst_mid_no_pulse: got %b want 0000", latch); end
        step();
        CLR_B = 1'b1; run = 1'b1;
        step();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || latch !== 4'b0000) begin errors++; $display("FAIL restart_read: rd=%b addr=%h latch=%b want 1/00/0000", mem_rd, mem_addr, latch); end
        step();
        checks++; if (latch !== 4'b0001) begin errors++; $display("FAIL restart_latch0: got %b want 0001", latch); end
        repeat (7) step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL restart_valid: got %b want 1", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dp[i] !== exp_b[i]) begin errors++; $display("FAIL restart_byte%0d: got %h want %h", i, dp[i], exp_b[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 4; i++) dp[i] = 8'h00;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
        mem[8'h04] = 8'h55; mem[8'h05] = 8'h66; mem[8'h06] = 8'h77; mem[8'h07] = 8'h88;
        mem[8'h40] = 8'hC0; mem[8'h41] = 8'hC1; mem[8'h42] = 8'hC2; mem[8'h43] = 8'hC3;
        mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2;
        mem[8'h80] = 8'hD0; mem[8'h81] = 8'hD1; mem[8'h82] = 8'hD2; mem[8'h83] = 8'hD3;
        test_reset();
        test_single_fetch();
        test_wait_states();
        test_branch();
        test_priority_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
